// File: rtl/serial_word_framer.sv
// rtl/serial_word_framer.sv - bit-serial sync hunter and payload word assembler
module serial_word_framer #(
    parameter int                SYNC_W   = 4,
    parameter logic [SYNC_W-1:0] SYNC_PAT = 4'b1011,
    parameter int                WORD_W   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              din,
    output logic              in_frame,
    output logic [WORD_W-1:0] word,
    output logic              word_valid,
    output logic [7:0]        frame_cnt
);

    localparam int FILL_W = $clog2(SYNC_W + 1);
    localparam int CNT_W  = (WORD_W > 1) ? $clog2(WORD_W + 1) : 1;

    typedef enum logic {
        HUNT    = 1'b0,
        CAPTURE = 1'b1
    } state_t;

    state_t            state;
    logic [SYNC_W-1:0] window;
    logic [FILL_W-1:0] fill;
    logic [CNT_W-1:0]  bit_cnt;
    logic [WORD_W-1:0] shreg;

    logic [SYNC_W:0]   win_cat;
    logic [WORD_W:0]   sh_cat;
    logic [SYNC_W-1:0] win_shift;
    logic [WORD_W-1:0] sh_shift;
    logic              fill_full;
    logic              last_bit;

    // Concatenate-then-truncate keeps the shift legal for 1-bit payloads too.
    always_comb begin
        win_cat   = {window, din};
        sh_cat    = {shreg, din};
        win_shift = win_cat[SYNC_W-1:0];
        sh_shift  = sh_cat[WORD_W-1:0];
        // fill stops at SYNC_W-1: the bit arriving now completes a full window
        fill_full = (fill >= FILL_W'(SYNC_W - 1));
        last_bit  = (bit_cnt == CNT_W'(WORD_W - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= HUNT;
            window     <= '0;
            fill       <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            in_frame   <= 1'b0;
            word       <= '0;
            word_valid <= 1'b0;
            frame_cnt  <= 8'd0;
        end else begin
            word_valid <= 1'b0;
            if (en) begin
                case (state)
                    HUNT: begin
                        if (fill_full && (win_shift == SYNC_PAT)) begin
                            state    <= CAPTURE;
                            in_frame <= 1'b1;
                            window   <= '0;
                            fill     <= '0;
                            bit_cnt  <= '0;
                        end else begin
                            window <= win_shift;
                            if (!fill_full) begin
                                fill <= fill + FILL_W'(1);
                            end
                        end
                    end
                    CAPTURE: begin
                        if (last_bit) begin
                            word       <= sh_shift;
                            word_valid <= 1'b1;
                            if (frame_cnt != 8'hFF) begin
                                frame_cnt <= frame_cnt + 8'd1;
                            end
                            state    <= HUNT;
                            in_frame <= 1'b0;
                            bit_cnt  <= '0;
                            shreg    <= '0;
                            window   <= '0;
                            fill     <= '0;
                        end else begin
                            shreg   <= sh_shift;
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end
                    default: begin
                        state    <= HUNT;
                        in_frame <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_serial_word_framer.sv
// tb/tb_serial_word_framer.sv - scoreboard bench for serial_word_framer
module tb_serial_word_framer;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       din;
    logic       in_frame;
    logic [7:0] word;
    logic       word_valid;
    logic [7:0] frame_cnt;

    int n_cmp = 0;
    int n_err = 0;
    int n_pulses = 0;
    int exp_cnt = 0;

    logic [7:0] exp_word_q[$];
    logic [7:0] exp_cnt_q[$];

    serial_word_framer #(.SYNC_W(4), .SYNC_PAT(4'b1011), .WORD_W(8)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .en(en),
        .din(din),
        .in_frame(in_frame),
        .word(word),
        .word_valid(word_valid),
        .frame_cnt(frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pops the scoreboard whenever the DUT strobes a word.
    always @(posedge clk) begin
        #2;
        if (rst_n && word_valid) begin
            n_pulses++;
            n_cmp++;
            if (exp_word_q.size() == 0) begin
                n_err++;
                $display("FAIL sb_unexpected: word_valid with word=%h, nothing expected", word);
            end else begin
                logic [7:0] ew;
                logic [7:0] ec;
                ew = exp_word_q.pop_front();
                ec = exp_cnt_q.pop_front();
                if (word !== ew) begin
                    n_err++;
                    $display("FAIL sb_word: got %h expected %h", word, ew);
                end
                n_cmp++;
                if (frame_cnt !== ec) begin
                    n_err++;
                    $display("FAIL sb_frame_cnt: got %0d expected %0d", frame_cnt, ec);
                end
            end
        end
    end

    task automatic send_bit(input logic b);
        en  = 1'b1;
        din = b;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        en = 1'b0;
        for (int i = 0; i < n; i++) begin
            din = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_word(input logic [7:0] w);
        exp_cnt = (exp_cnt < 255) ? exp_cnt + 1 : 255;
        exp_word_q.push_back(w);
        exp_cnt_q.push_back(8'(exp_cnt));
    endtask

    task automatic send_payload(input logic [7:0] w, input int gap);
        for (int i = 7; i >= 0; i--) begin
            if (i == 0) expect_word(w);
            send_bit(w[i]);
            if (gap > 0) idle(gap);
        end
    endtask

    task automatic check_drained(input string name);
        n_cmp++;
        if (exp_word_q.size() != 0) begin
            n_err++;
            $display("FAIL %s_drained: %0d words outstanding, expected 0", name, exp_word_q.size());
        end
    endtask

    task automatic do_reset_pulse();
        rst_n = 1'b0;
        #1;
        exp_word_q.delete();
        exp_cnt_q.delete();
        exp_cnt = 0;
    endtask

    task automatic test_reset();
        en = 1'b0;
        din = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({in_frame, word, word_valid, frame_cnt} !== 18'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got %b expected 0", {in_frame, word, word_valid, frame_cnt});
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        logic [3:0] sync;
        logic [3:0] exp_if;
        sync = 4'b1011;
        exp_if = 4'b0001;
        for (int i = 3; i >= 0; i--) begin
            send_bit(sync[i]);
            n_cmp++;
            if (in_frame !== exp_if[i]) begin
                n_err++;
                $display("FAIL basic_in_frame_bit%0d: got %b expected %b", 3 - i, in_frame, exp_if[i]);
            end
        end
        send_payload(8'hA5, 0);
        n_cmp++;
        if (word_valid !== 1'b1 || in_frame !== 1'b0 || word !== 8'hA5 || frame_cnt !== 8'd1) begin
            n_err++;
            $display("FAIL basic_done: vld=%b inf=%b word=%h cnt=%0d expected 1 0 a5 1", word_valid, in_frame, word, frame_cnt);
        end
        idle(1);
        n_cmp++;
        if (word_valid !== 1'b0 || word !== 8'hA5) begin
            n_err++;
            $display("FAIL basic_strobe_width: vld=%b word=%h expected 0 a5", word_valid, word);
        end
        check_drained("basic");
    endtask

    task automatic test_gaps();
        logic [3:0] sync;
        logic [7:0] pay;
        sync = 4'b1011;
        pay = 8'hA5;
        do_reset_pulse();
        rst_n = 1'b1;
        for (int i = 3; i >= 0; i--) begin
            send_bit(sync[i]);
            idle(3);
        end
        n_cmp++;
        if (in_frame !== 1'b1) begin
            n_err++;
            $display("FAIL gaps_in_frame_after_sync: got %b expected 1", in_frame);
        end
        for (int i = 7; i >= 1; i--) begin
            send_bit(pay[i]);
            for (int g = 0; g < 3; g++) begin
                idle(1);
                n_cmp++;
                if (in_frame !== 1'b1) begin
                    n_err++;
                    $display("FAIL gaps_in_frame_hold: got %b expected 1", in_frame);
                end
            end
        end
        expect_word(pay);
        send_bit(pay[0]);
        idle(1);
        n_cmp++;
        if (word_valid !== 1'b0 || word !== 8'hA5 || frame_cnt !== 8'd1 || in_frame !== 1'b0) begin
            n_err++;
            $display("FAIL gaps_result: vld=%b word=%h cnt=%0d inf=%b expected 0 a5 1 0", word_valid, word, frame_cnt, in_frame);
        end
        idle(2);
        check_drained("gaps");
    endtask

    task automatic test_overlap_no_reuse();
        logic [5:0] pre;
        logic [3:0] tail;
        pre = 6'b101011;
        tail = 4'b1011;
        for (int i = 5; i >= 0; i--) begin
            send_bit(pre[i]);
            n_cmp++;
            if (in_frame !== (i == 0)) begin
                n_err++;
                $display("FAIL overlap_in_frame_bit%0d: got %b expected %b", 5 - i, in_frame, (i == 0));
            end
        end
        send_payload(8'hFF, 0);
        // 0,1,1 would complete 1011 only if the last payload bit were reused
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        n_cmp++;
        if (in_frame !== 1'b0) begin
            n_err++;
            $display("FAIL no_reuse_payload: in_frame=%b expected 0", in_frame);
        end
        for (int i = 3; i >= 0; i--) begin
            send_bit(tail[i]);
            n_cmp++;
            if (in_frame !== (i == 0)) begin
                n_err++;
                $display("FAIL no_reuse_fresh_bit%0d: got %b expected %b", 3 - i, in_frame, (i == 0));
            end
        end
        send_payload(8'h5A, 0);
        idle(1);
        check_drained("overlap");
    endtask

    task automatic test_reset_mid_capture();
        logic [3:0] sync;
        sync = 4'b1011;
        for (int i = 3; i >= 0; i--) send_bit(sync[i]);
        for (int i = 0; i < 5; i++) send_bit(1'($urandom_range(0, 1)));
        en = 1'b0;
        do_reset_pulse();
        n_cmp++;
        if (word !== 8'd0 || frame_cnt !== 8'd0 || in_frame !== 1'b0 || word_valid !== 1'b0) begin
            n_err++;
            $display("FAIL midcap_async_reset: word=%h cnt=%0d inf=%b vld=%b expected all 0", word, frame_cnt, in_frame, word_valid);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 3; i >= 0; i--) send_bit(sync[i]);
        send_payload(8'h3C, 0);
        n_cmp++;
        if (word !== 8'h3C || frame_cnt !== 8'd1 || word_valid !== 1'b1) begin
            n_err++;
            $display("FAIL midcap_refill: word=%h cnt=%0d vld=%b expected 3c 1 1", word, frame_cnt, word_valid);
        end
        idle(1);
        check_drained("midcap");
    endtask

    task automatic test_saturation();
        logic [3:0] sync;
        logic [7:0] w;
        int start_pulses;
        sync = 4'b1011;
        start_pulses = n_pulses;
        for (int f = 0; f < 256; f++) begin
            w = 8'($urandom);
            for (int i = 3; i >= 0; i--) send_bit(sync[i]);
            send_payload(w, 0);
        end
        idle(1);
        n_cmp++;
        if (frame_cnt !== 8'd255) begin
            n_err++;
            $display("FAIL sat_frame_cnt: got %0d expected 255", frame_cnt);
        end
        n_cmp++;
        if (n_pulses - start_pulses != 256) begin
            n_err++;
            $display("FAIL sat_pulses: got %0d expected 256", n_pulses - start_pulses);
        end
        check_drained("sat");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gaps();
        test_overlap_no_reuse();
        test_reset_mid_capture();
        test_saturation();
        idle(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
